// File: rtl/uart_tx_v2_pkg.sv
// Shared UART types, frame-setting decoders and constants.
// Also used by the RX successor.
package uart_pkg;

   localparam int BREAK_MIN_BITS = 12;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_ODD   = 3'd1,
      PAR_EVEN  = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_e;

   typedef enum logic [1:0] {
      STOP_1   = 2'd0,
      STOP_1P5 = 2'd1,
      STOP_2   = 2'd2
   } stop_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } tx_state_e;

   // Codes 5-7 select 8 bits; the result never exceeds the instance's widest field.
   function automatic int unsigned decode_data_bits(input logic [2:0] code,
                                                    input int unsigned max_bits);
      int unsigned n;
      case (code)
         3'd0:    n = 5;
         3'd1:    n = 6;
         3'd2:    n = 7;
         3'd3:    n = 8;
         3'd4:    n = 9;
         default: n = 8;
      endcase
      if (n > max_bits) n = max_bits;
      return n;
   endfunction

   function automatic parity_e decode_parity(input logic [2:0] code);
      return (code > 3'd4) ? PAR_NONE : parity_e'(code);
   endfunction

   function automatic stop_e decode_stop(input logic [1:0] code);
      return (code == 2'd0) ? STOP_1 : ((code == 2'd1) ? STOP_1P5 : STOP_2);
   endfunction

endpackage

// File: rtl/uart_tx_v2_if.sv
// Ready/valid frame handshake between the TX FIFO (master) and the transmitter (slave).
interface uart_tx_v2_if #(
   parameter int MAX_DATA_BITS = 9
);
   logic                     in_valid;
   logic                     in_ready;
   logic [MAX_DATA_BITS-1:0] in_data;
   logic [2:0]               data_bits;
   logic [2:0]               parity;
   logic [1:0]               stop_bits;

   modport master (
      output in_valid, in_data, data_bits, parity, stop_bits,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, data_bits, parity, stop_bits,
      output in_ready
   );
endinterface

// File: rtl/uart_tx_v2_baud_tick.sv
// Baud tick generator: one-clock tick every div+1 clocks, restartable via clear.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;

   assign tick = (r_cnt == div);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_v2.sv
// UART transmitter with internal baud tick, ready/valid input and break generation.
// Frame settings are captured at acceptance; all outputs are registered.
module uart_tx_v2 #(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_W         = 16,
   parameter int OVERSAMPLE    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] baud_div,
   uart_tx_v2_if.slave      in_if,
   input  logic             break_req,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   import uart_pkg::*;

   localparam int BRK_TICKS = BREAK_MIN_BITS * OVERSAMPLE;
   localparam int SUB_W     = $clog2(BRK_TICKS);

   localparam logic [SUB_W-1:0] BIT_LAST    = SUB_W'(OVERSAMPLE - 1);
   localparam logic [SUB_W-1:0] STOP1_LAST  = SUB_W'(OVERSAMPLE - 1);
   localparam logic [SUB_W-1:0] STOP15_LAST = SUB_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
   localparam logic [SUB_W-1:0] STOP2_LAST  = SUB_W'(2 * OVERSAMPLE - 1);
   localparam logic [SUB_W-1:0] BRK_LAST    = SUB_W'(BRK_TICKS - 1);

   tx_state_e                r_state, w_state_n;
   logic [MAX_DATA_BITS-1:0] r_shreg, w_shreg_n;
   logic [SUB_W-1:0]         r_sub, w_sub_n;
   logic [3:0]               r_bit, w_bit_n;
   logic [3:0]               r_nbits;
   logic                     r_par_en;
   logic                     r_par_bit;
   stop_e                    r_stop;
   logic [DIV_W-1:0]         r_div;
   logic                     r_from_brk;
   logic                     r_tx, r_busy, r_done, r_in_ready;

   logic                     w_tick;
   logic                     w_accept, w_brk_entry, w_clear;
   int unsigned              w_nbits;
   parity_e                  w_par_mode;
   logic [MAX_DATA_BITS-1:0] w_mask, w_data;
   logic                     w_par_bit;
   logic [SUB_W-1:0]         w_stop_last;
   logic                     w_tx_n, w_done_n;

   // break_req has priority over a frame offered in the same cycle
   assign w_accept    = (r_state == ST_IDLE) && in_if.in_valid && r_in_ready && !break_req;
   assign w_brk_entry = (r_state == ST_IDLE) && break_req;
   assign w_clear     = w_accept || w_brk_entry;

   uart_baud_tick #(
      .DIV_W(DIV_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(w_clear),
      .div  (r_div),
      .tick (w_tick)
   );

   always_comb begin
      w_nbits    = decode_data_bits(in_if.data_bits, MAX_DATA_BITS);
      w_par_mode = decode_parity(in_if.parity);
      w_mask     = '0;
      for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
         w_mask[i] = (i < w_nbits);
      end
      w_data = in_if.in_data & w_mask;
      case (w_par_mode)
         PAR_ODD:  w_par_bit = ~^w_data;
         PAR_EVEN: w_par_bit = ^w_data;
         PAR_MARK: w_par_bit = 1'b1;
         default:  w_par_bit = 1'b0;
      endcase
   end

   always_comb begin
      case (r_stop)
         STOP_1:   w_stop_last = STOP1_LAST;
         STOP_1P5: w_stop_last = STOP15_LAST;
         default:  w_stop_last = STOP2_LAST;
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      w_shreg_n = r_shreg;
      w_sub_n   = r_sub;
      w_bit_n   = r_bit;
      w_done_n  = 1'b0;
      w_tx_n    = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (w_brk_entry) begin
               w_state_n = ST_BREAK;
               w_sub_n   = '0;
            end else if (w_accept) begin
               w_state_n = ST_START;
               w_sub_n   = '0;
               w_bit_n   = '0;
               w_shreg_n = w_data;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_sub == BIT_LAST) begin
                  w_state_n = ST_DATA;
                  w_sub_n   = '0;
               end else begin
                  w_sub_n = r_sub + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_sub == BIT_LAST) begin
                  w_sub_n   = '0;
                  w_shreg_n = r_shreg >> 1;
                  if (r_bit == r_nbits - 4'd1) begin
                     w_state_n = r_par_en ? ST_PARITY : ST_STOP;
                  end else begin
                     w_bit_n = r_bit + 4'd1;
                  end
               end else begin
                  w_sub_n = r_sub + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               if (r_sub == BIT_LAST) begin
                  w_state_n = ST_STOP;
                  w_sub_n   = '0;
               end else begin
                  w_sub_n = r_sub + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (r_sub == w_stop_last) begin
                  w_state_n = ST_IDLE;
                  w_sub_n   = '0;
                  w_done_n  = !r_from_brk;
               end else begin
                  w_sub_n = r_sub + 1'b1;
               end
            end
         end
         ST_BREAK: begin
            // sub-counter parks on its last value once the minimum break has elapsed
            if (w_tick) begin
               if (r_sub == BRK_LAST) begin
                  if (!break_req) begin
                     w_state_n = ST_STOP;
                     w_sub_n   = '0;
                  end
               end else begin
                  w_sub_n = r_sub + 1'b1;
               end
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_sub_n   = '0;
         end
      endcase

      case (w_state_n)
         ST_START, ST_BREAK: w_tx_n = 1'b0;
         ST_DATA:            w_tx_n = w_shreg_n[0];
         ST_PARITY:          w_tx_n = r_par_bit;
         default:            w_tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_shreg    <= '0;
         r_sub      <= '0;
         r_bit      <= '0;
         r_nbits    <= 4'd8;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_stop     <= STOP_1;
         r_div      <= '0;
         r_from_brk <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_shreg    <= w_shreg_n;
         r_sub      <= w_sub_n;
         r_bit      <= w_bit_n;
         r_tx       <= w_tx_n;
         r_busy     <= (w_state_n != ST_IDLE);
         r_done     <= w_done_n;
         r_in_ready <= (w_state_n == ST_IDLE) && !break_req;
         if (w_accept) begin
            r_nbits    <= 4'(w_nbits);
            r_par_en   <= (w_par_mode != PAR_NONE);
            r_par_bit  <= w_par_bit;
            r_stop     <= decode_stop(in_if.stop_bits);
            r_div      <= baud_div;
            r_from_brk <= 1'b0;
         end else if (w_brk_entry) begin
            // the mark after a break is always a single bit time
            r_stop     <= STOP_1;
            r_div      <= baud_div;
            r_from_brk <= 1'b1;
         end
      end
   end

   assign tx             = r_tx;
   assign busy           = r_busy;
   assign frame_done     = r_done;
   assign in_if.in_ready = r_in_ready;

endmodule

// File: doc/uart_tx_v2.md
# uart_tx_v2

Parametrised single-clock UART transmitter that replaces the separate baud-clock TX path with an internal tick generator and a ready/valid input handshake. It supports 5–MAX_DATA_BITS data bits, five parity modes, 1/1.5/2 stop bits and line-break generation. It sits between the TX FIFO (or a register write port) and the `tx` pad; every frame setting is captured per frame at acceptance.

## Interface
- `MAX_DATA_BITS`, 9: widest data field; legal range 5–9.
- `DIV_W`, 16: width of `baud_div`.
- `OVERSAMPLE`, 16: ticks per bit time; must be even and ≥4.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `baud_div` in DIV_W: clocks per tick minus 1; tick period is `baud_div`+1 clocks.
- `in_valid` in 1: frame data offered.
- `in_ready` out 1: block can accept a frame.
- `in_data` in MAX_DATA_BITS: payload, LSB first; bits at or above the selected width are ignored.
- `data_bits` in 3: 0→5, 1→6, 2→7, 3→8, 4→9; 5–7→8; any value above MAX_DATA_BITS clamps to MAX_DATA_BITS.
- `parity` in 3: 0 none, 1 odd, 2 even, 3 mark, 4 space; 5–7 behave as none.
- `stop_bits` in 2: 0→1, 1→1.5, 2/3→2.
- `break_req` in 1: hold line low (break).
- `tx` out 1: serial line, idle high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at the end of a frame's stop period.

## Operation
- States:
  - IDLE → START on accept.
  - IDLE → BREAK when `break_req`.
  - START → DATA.
  - DATA → PARITY after the last data bit, or → STOP if parity is none.
  - PARITY → STOP.
  - STOP → IDLE.
  - BREAK → STOP when `break_req` is low and the minimum break time has elapsed.
- `in_ready` = (state==IDLE) && !`break_req`, driven from registers. A frame is accepted when `in_valid` && `in_ready`.
- On accept, latch `in_data`, the decoded width, parity mode, stop length and `baud_div`. Input changes after accept do not affect the frame in flight.
- Parity is computed over the selected data bits only:
  - odd: `tx` = ~^data.
  - even: `tx` = ^data.
  - mark: 1.
  - space: 0.
- Tick counter: cleared on accept and on BREAK entry. It counts 0..`baud_div` and emits a tick when it equals `baud_div`; `baud_div`=0 gives a tick every clock.
- Bit counter: a sub-bit counter counts ticks per bit. A bit ends after OVERSAMPLE ticks. STOP lasts 1, 1.5 or 2 × OVERSAMPLE ticks.
- Per-state line level:
  - START: `tx`=0.
  - DATA: `tx`=current LSB; the shift register shifts right at the end of each bit.
  - STOP: `tx`=1.
  - BREAK: `tx`=0.
- Break:
  - Minimum break time is 12 × OVERSAMPLE ticks. Break continues while `break_req` stays high.
  - Break is followed by exactly one bit time of mark (STOP with 1 stop bit).
  - BREAK→STOP→IDLE does not pulse `frame_done`.
- If `break_req` and `in_valid` are both high in IDLE, break wins and no frame is accepted.
- `break_req` is ignored outside IDLE; it is sampled again on return to IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, `in_ready`=0 while `rst` is high. `in_ready` is 1 on the first cycle after `rst` falls (if `break_req` is low).
- `rst` mid-frame: all state is discarded and `tx`=1 on the next edge.
- All outputs are registered. `tx` falls on the clock edge after the accept edge.
- The start bit lasts exactly OVERSAMPLE × (`baud_div`+1) clocks. Every data and parity bit has the same length.
- `frame_done` is high for one cycle on the last tick of the stop period. The state is IDLE on the following cycle, with `in_ready`=1.
- Back-to-back frames with `in_valid` held high: the stop period is stretched by exactly 1 clock (the IDLE accept cycle) before the next start bit.
- Frame length in ticks = OVERSAMPLE × (1 + N + P) + stop ticks, where N is the data width and P is 1 if parity is enabled.

## Structure
- Package `uart_pkg` holds:
  - parity enum `parity_e`;
  - stop enum `stop_e`;
  - state enum `tx_state_e`;
  - function `decode_data_bits(code, MAX_DATA_BITS)`;
  - constant `BREAK_MIN_BITS` = 12.
- Sub-module `uart_baud_tick`: `clk`, `rst`, `clear`, `div`[DIV_W] → `tick`. It will be reused by the RX successor.
- The FSM, shift register and counters live in `uart_tx_v2`.

## Test plan
- 8N1 frame: `baud_div`=0, OVERSAMPLE=16, `in_data`=0x55. Required: `tx` low 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks. `frame_done` pulses at clock 160 after `tx` falls.
- 7E2 frame: `in_data`=0x41, `baud_div`=3. Required: every bit lasts 64 clocks, parity bit=0, stop high for 128 clocks.
- 9O1 frame: `in_data`=0x1FF. Required: parity bit=0. Then 5N1 with `in_data`=0x1E0: data bits 00000 and upper bits ignored.
- Stop length 1.5 (`stop_bits`=1), `baud_div`=0. Required: stop high exactly 24 clocks before the next start bit, with `in_valid` held, plus the 1-clock accept gap.
- Break precedence: `break_req` and `in_valid` rise together in IDLE, and `break_req` is held 5 bit times. Required: no accept, `tx` low 12 bit times, then 1 bit time high, then `in_ready`=1 and no `frame_done`.
- Reset mid-frame: assert `rst` mid-DATA. Required: `tx`=1 next edge and `in_ready`=0 during reset. After release, a fresh 0xA3 8N1 frame transmits correctly.
